// File: rtl/psl_cmd_scheduler.sv
// psl_cmd_scheduler
//   Shares the single PSL command interface between N_REQ AFU requesters.
//   Round-robin grant, command-credit accounting, tag allocation from a pool
//   of 2**TAG_W tags, and routing of PSL responses back to the owning requester.
//
// Ports
//   ha_pclock, ha_reset_n           clock, asynchronous active-low reset
//   start, ha_croom                 load credits, free every tag, clear err
//   req_valid/req_ready             per-requester handshake (ready is one-hot)
//   req_com/req_cea/req_csize       packed per-requester command fields
//   ah_c*                           registered command to the PSL
//   ha_r*                           PSL response inputs
//   rsp_valid/rsp_tag/rsp_code      response routed to the owning requester
//   credits, outstanding, err       status (err is sticky until start)
//
// Configuration
//   PSL_CMD_PARITY_EN  defined: odd parity on ah_ctag/ah_com/ah_cea and
//                      ha_rtagpar is checked. Undefined: parity outputs are
//                      tied to 1 and ha_rtagpar is ignored.
module psl_cmd_scheduler #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 5
) (
  input  logic                 ha_pclock,
  input  logic                 ha_reset_n,
  input  logic                 start,
  input  logic [7:0]           ha_croom,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*13-1:0]  req_com,
  input  logic [N_REQ*64-1:0]  req_cea,
  input  logic [N_REQ*12-1:0]  req_csize,
  output logic                 ah_cvalid,
  output logic [7:0]           ah_ctag,
  output logic [12:0]          ah_com,
  output logic [63:0]          ah_cea,
  output logic [11:0]          ah_csize,
  output logic [2:0]           ah_cabt,
  output logic [15:0]          ah_cch,
  output logic                 ah_ctagpar,
  output logic                 ah_compar,
  output logic                 ah_ceapar,
  input  logic                 ha_rvalid,
  input  logic [7:0]           ha_rtag,
  input  logic                 ha_rtagpar,
  input  logic [7:0]           ha_response,
  input  logic [8:0]           ha_rcredits,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [7:0]           rsp_tag,
  output logic [7:0]           rsp_code,
  output logic [8:0]           credits,
  output logic [TAG_W:0]       outstanding,
  output logic                 err
);
  localparam int N_TAG = 1 << TAG_W;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_par(input logic [63:0] v);
    return ~(^v);
  endfunction

  logic [N_TAG-1:0] tag_busy;
  logic [IDX_W-1:0] owner [N_TAG];
  logic [IDX_W-1:0] rr_ptr;

  logic             found;
  logic [IDX_W-1:0] grant_idx;
  logic             tag_avail;
  logic [TAG_W-1:0] free_tag;
  logic             accept;
  logic [TAG_W-1:0] rtag_idx;
  logic             rtag_in_pool;
  logic             par_ok;
  logic             rsp_hit;
  logic             rsp_bad;
  logic [10:0]      ret;
  logic [10:0]      cred_sum;
  logic [8:0]       cred_next;
  logic             cred_sat;

  assign ah_cabt = 3'b000;
  assign ah_cch  = 16'h0000;

  // Lowest free tag and round-robin grant starting at rr_ptr.
  always_comb begin
    tag_avail = 1'b0;
    free_tag  = '0;
    found     = 1'b0;
    grant_idx = '0;
    // Descending scan so the lowest free index is the one left standing.
    for (int t = N_TAG - 1; t >= 0; t--) begin
      if (!tag_busy[t]) begin
        tag_avail = 1'b1;
        free_tag  = TAG_W'(t);
      end else begin
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && (credits != 9'd0) && tag_avail && !start &&
          req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        found     = 1'b1;
        grant_idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      end else begin
      end
    end
    if (found) begin
      req_ready = N_REQ'(1) << grant_idx;
    end else begin
      req_ready = '0;
    end
    accept = found;
  end

  // Response decode and signed credit update with saturation.
  always_comb begin
    rtag_idx     = ha_rtag[TAG_W-1:0];
    rtag_in_pool = ((ha_rtag >> TAG_W) == 8'd0);
    rsp_hit      = ha_rvalid && rtag_in_pool && tag_busy[rtag_idx] && par_ok;
    rsp_bad      = ha_rvalid && !rsp_hit;
    if (ha_rvalid) begin
      ret = {{2{ha_rcredits[8]}}, ha_rcredits};
    end else begin
      ret = 11'd0;
    end
    cred_sum = {2'b00, credits} - {10'd0, accept} + ret;
    cred_sat = 1'b0;
    if (cred_sum[10]) begin
      cred_next = 9'd0;
      cred_sat  = 1'b1;
    end else if (cred_sum > 11'd255) begin
      cred_next = 9'd255;
      cred_sat  = 1'b1;
    end else begin
      cred_next = cred_sum[8:0];
    end
  end

  // Scheduler state, command register and response routing.
  always_ff @(posedge ha_pclock or negedge ha_reset_n) begin
    if (!ha_reset_n) begin
      credits     <= 9'd0;
      tag_busy    <= '0;
      rr_ptr      <= '0;
      outstanding <= '0;
      err         <= 1'b0;
      ah_cvalid   <= 1'b0;
      ah_ctag     <= 8'd0;
      ah_com      <= 13'd0;
      ah_cea      <= 64'd0;
      ah_csize    <= 12'd0;
      rsp_valid   <= '0;
      rsp_tag     <= 8'd0;
      rsp_code    <= 8'd0;
      for (int t = 0; t < N_TAG; t++) begin
        owner[t] <= '0;
      end
    end else if (start) begin
      credits     <= {1'b0, ha_croom};
      tag_busy    <= '0;
      rr_ptr      <= '0;
      outstanding <= '0;
      err         <= 1'b0;
      ah_cvalid   <= 1'b0;
      rsp_valid   <= '0;
    end else begin
      credits     <= cred_next;
      err         <= err | rsp_bad | cred_sat;
      ah_cvalid   <= accept;
      outstanding <= outstanding + {{TAG_W{1'b0}}, accept} - {{TAG_W{1'b0}}, rsp_hit};
      // The tag being freed is still busy this cycle, so it cannot be the
      // one allocated; the two bit updates never collide.
      if (accept) begin
        tag_busy[free_tag] <= 1'b1;
        owner[free_tag]    <= grant_idx;
        ah_ctag            <= {{(8 - TAG_W){1'b0}}, free_tag};
        ah_com             <= req_com[int'(grant_idx) * 13 +: 13];
        ah_cea             <= req_cea[int'(grant_idx) * 64 +: 64];
        ah_csize           <= req_csize[int'(grant_idx) * 12 +: 12];
        rr_ptr             <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
      if (rsp_hit) begin
        tag_busy[rtag_idx] <= 1'b0;
        rsp_valid          <= N_REQ'(1) << owner[rtag_idx];
        rsp_tag            <= ha_rtag;
        rsp_code           <= ha_response;
      end else begin
        rsp_valid          <= '0;
      end
    end
  end

`ifdef PSL_CMD_PARITY_EN
  assign par_ok = (ha_rtagpar == odd_par({56'd0, ha_rtag}));

  // Command parity, registered alongside the command fields.
  always_ff @(posedge ha_pclock or negedge ha_reset_n) begin
    if (!ha_reset_n) begin
      ah_ctagpar <= 1'b1;
      ah_compar  <= 1'b1;
      ah_ceapar  <= 1'b1;
    end else if (accept && !start) begin
      ah_ctagpar <= odd_par({56'd0, {(8 - TAG_W){1'b0}}, free_tag});
      ah_compar  <= odd_par({51'd0, req_com[int'(grant_idx) * 13 +: 13]});
      ah_ceapar  <= odd_par(req_cea[int'(grant_idx) * 64 +: 64]);
    end else begin
      ah_ctagpar <= ah_ctagpar;
      ah_compar  <= ah_compar;
      ah_ceapar  <= ah_ceapar;
    end
  end
`else
  logic unused_rtagpar;
  assign unused_rtagpar = ha_rtagpar;
  assign par_ok         = 1'b1;
  assign ah_ctagpar     = 1'b1;
  assign ah_compar      = 1'b1;
  assign ah_ceapar      = 1'b1;
`endif

endmodule

// File: tb/tb_psl_cmd_scheduler.sv
// Directed bench for psl_cmd_scheduler (N_REQ=4, TAG_W=5).
module tb_psl_cmd_scheduler;
  logic         ha_pclock = 1'b0;
  logic         ha_reset_n;
  logic         start;
  logic [7:0]   ha_croom;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [51:0]  req_com;
  logic [255:0] req_cea;
  logic [47:0]  req_csize;
  logic         ah_cvalid;
  logic [7:0]   ah_ctag;
  logic [12:0]  ah_com;
  logic [63:0]  ah_cea;
  logic [11:0]  ah_csize;
  logic [2:0]   ah_cabt;
  logic [15:0]  ah_cch;
  logic         ah_ctagpar, ah_compar, ah_ceapar;
  logic         ha_rvalid;
  logic [7:0]   ha_rtag;
  logic         ha_rtagpar;
  logic [7:0]   ha_response;
  logic [8:0]   ha_rcredits;
  logic [3:0]   rsp_valid;
  logic [7:0]   rsp_tag;
  logic [7:0]   rsp_code;
  logic [8:0]   credits;
  logic [5:0]   outstanding;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  psl_cmd_scheduler #(.N_REQ(4), .TAG_W(5)) dut (
    .ha_pclock(ha_pclock), .ha_reset_n(ha_reset_n), .start(start), .ha_croom(ha_croom),
    .req_valid(req_valid), .req_ready(req_ready), .req_com(req_com), .req_cea(req_cea),
    .req_csize(req_csize), .ah_cvalid(ah_cvalid), .ah_ctag(ah_ctag), .ah_com(ah_com),
    .ah_cea(ah_cea), .ah_csize(ah_csize), .ah_cabt(ah_cabt), .ah_cch(ah_cch),
    .ah_ctagpar(ah_ctagpar), .ah_compar(ah_compar), .ah_ceapar(ah_ceapar),
    .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag), .ha_rtagpar(ha_rtagpar),
    .ha_response(ha_response), .ha_rcredits(ha_rcredits), .rsp_valid(rsp_valid),
    .rsp_tag(rsp_tag), .rsp_code(rsp_code), .credits(credits),
    .outstanding(outstanding), .err(err)
  );

  always #5 ha_pclock = ~ha_pclock;

  function automatic logic [12:0] exp_com(input int i);
    return 13'h100 + 13'(i);
  endfunction
  function automatic logic [63:0] exp_cea(input int i);
    return 64'hCAFE_0000_0000_0000 | (64'(i) << 8);
  endfunction
  function automatic logic [11:0] exp_csize(input int i);
    return 12'h080 + 12'(i);
  endfunction

  task automatic tick();
    @(posedge ha_pclock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rsp(input logic [7:0] tag, input logic [8:0] cr, input logic [7:0] code);
    ha_rvalid   = 1'b1;
    ha_rtag     = tag;
    ha_rtagpar  = ~(^tag);
    ha_rcredits = cr;
    ha_response = code;
  endtask

  task automatic rsp_off();
    ha_rvalid = 1'b0;
  endtask

  initial begin
    ha_reset_n = 1'b0; start = 1'b0; ha_croom = 8'd0; req_valid = 4'b0000;
    ha_rvalid = 1'b0; ha_rtag = 8'd0; ha_rtagpar = 1'b1; ha_response = 8'd0;
    ha_rcredits = 9'd0;
    for (int i = 0; i < 4; i++) begin
      req_com[13*i +: 13]  = exp_com(i);
      req_cea[64*i +: 64]  = exp_cea(i);
      req_csize[12*i +: 12] = exp_csize(i);
    end
    repeat (2) tick();
    chk("rst_cvalid", 64'(ah_cvalid), 64'd0);
    chk("rst_credits", 64'(credits), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_ctagpar", 64'(ah_ctagpar), 64'd1);
    chk("rst_cabt_cch", 64'({ah_cabt, ah_cch}), 64'd0);
    ha_reset_n = 1'b1;
    tick();

    // 1: two credits, three requesters
    start = 1'b1; ha_croom = 8'd2; req_valid = 4'b0111; #1;
    chk("t1_no_grant_on_start", 64'(req_ready), 64'd0);
    tick(); start = 1'b0; #1;
    chk("t1_credits_loaded", 64'(credits), 64'd2);
    chk("t1_grant0", 64'(req_ready), 64'b0001);
    tick();
    chk("t1_cvalid0", 64'(ah_cvalid), 64'd1);
    chk("t1_tag0", 64'(ah_ctag), 64'd0);
    chk("t1_com0", 64'(ah_com), 64'(exp_com(0)));
    chk("t1_cea0", ah_cea, exp_cea(0));
    chk("t1_csize0", 64'(ah_csize), 64'(exp_csize(0)));
    chk("t1_credits1", 64'(credits), 64'd1);
    req_valid = 4'b0110; #1;
    chk("t1_grant1", 64'(req_ready), 64'b0010);
    tick();
    chk("t1_tag1", 64'(ah_ctag), 64'd1);
    chk("t1_com1", 64'(ah_com), 64'(exp_com(1)));
    chk("t1_credits0", 64'(credits), 64'd0);
    chk("t1_outstanding2", 64'(outstanding), 64'd2);
    req_valid = 4'b0100; #1;
    chk("t1_req2_stalled", 64'(req_ready), 64'd0);
    tick();
    chk("t1_cvalid_drop", 64'(ah_cvalid), 64'd0);

    // 2: response returns a credit and frees tag 0
    rsp(8'd0, 9'd1, 8'h5A); #1;
    chk("t2_still_stalled", 64'(req_ready), 64'd0);
    tick(); rsp_off();
    chk("t2_rsp_valid", 64'(rsp_valid), 64'b0001);
    chk("t2_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("t2_rsp_code", 64'(rsp_code), 64'h5A);
    chk("t2_credits", 64'(credits), 64'd1);
    chk("t2_outstanding", 64'(outstanding), 64'd1);
    #1;
    chk("t2_grant2", 64'(req_ready), 64'b0100);
    tick();
    chk("t2_cvalid", 64'(ah_cvalid), 64'd1);
    chk("t2_tag_reuse0", 64'(ah_ctag), 64'd0);
    chk("t2_com2", 64'(ah_com), 64'(exp_com(2)));
    chk("t2_rsp_drop", 64'(rsp_valid), 64'd0);
    req_valid = 4'b0000;

    // 4: issue and response in the same cycle
    rsp(8'd1, 9'd1, 8'h11); tick(); rsp_off();
    chk("t4_rsp_req1", 64'(rsp_valid), 64'b0010);
    chk("t4_credits_pre", 64'(credits), 64'd1);
    req_valid = 4'b1000; rsp(8'd0, 9'd1, 8'h22); #1;
    chk("t4_grant3", 64'(req_ready), 64'b1000);
    tick(); rsp_off(); req_valid = 4'b0000;
    chk("t4_tag_not_freed_one", 64'(ah_ctag), 64'd1);
    chk("t4_credits_stay", 64'(credits), 64'd1);
    chk("t4_rsp_req2", 64'(rsp_valid), 64'b0100);
    chk("t4_outstanding", 64'(outstanding), 64'd1);

    // 5: response to an unallocated tag
    rsp(8'd7, 9'd2, 8'h33); tick(); rsp_off();
    chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_credits", 64'(credits), 64'd3);
    chk("t5_outstanding", 64'(outstanding), 64'd1);

    // 3: four requesters, eight credits
    start = 1'b1; ha_croom = 8'd8; tick(); start = 1'b0;
    chk("t3_err_cleared", 64'(err), 64'd0);
    chk("t3_credits", 64'(credits), 64'd8);
    chk("t3_outstanding0", 64'(outstanding), 64'd0);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t3_rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk("t3_rr_tag", 64'(ah_ctag), 64'(k));
      chk("t3_rr_com", 64'(ah_com), 64'(exp_com(k % 4)));
    end
    #1;
    chk("t3_out_of_credit", 64'(req_ready), 64'd0);
    chk("t3_credits0", 64'(credits), 64'd0);
    chk("t3_outstanding8", 64'(outstanding), 64'd8);
    req_valid = 4'b0000;

    // credit underflow
    rsp(8'd0, 9'h1FF, 8'h44); tick(); rsp_off();
    chk("uf_credits", 64'(credits), 64'd0);
    chk("uf_err", 64'(err), 64'd1);
    chk("uf_rsp", 64'(rsp_valid), 64'b0001);
    chk("uf_outstanding", 64'(outstanding), 64'd7);

    // credit overflow
    start = 1'b1; ha_croom = 8'd255; tick(); start = 1'b0;
    req_valid = 4'b0001; tick(); req_valid = 4'b0000;
    chk("of_credits_pre", 64'(credits), 64'd254);
    rsp(8'd0, 9'd3, 8'h55); tick(); rsp_off();
    chk("of_credits_sat", 64'(credits), 64'd255);
    chk("of_err", 64'(err), 64'd1);
    chk("of_rsp", 64'(rsp_valid), 64'b0001);

    // tag outside the pool
    start = 1'b1; ha_croom = 8'd4; tick(); start = 1'b0;
    chk("op_err_cleared", 64'(err), 64'd0);
    rsp(8'd40, 9'd1, 8'h66); tick(); rsp_off();
    chk("op_err", 64'(err), 64'd1);
    chk("op_no_rsp", 64'(rsp_valid), 64'd0);
    chk("op_credits", 64'(credits), 64'd5);

    // parity
    start = 1'b1; ha_croom = 8'd4; tick(); start = 1'b0;
    req_valid = 4'b0010; tick(); req_valid = 4'b0000;
    chk("par_tag", 64'(ah_ctag), 64'd0);
`ifdef PSL_CMD_PARITY_EN
    chk("par_ctagpar", 64'(ah_ctagpar), 64'(~(^ah_ctag)));
    chk("par_compar", 64'(ah_compar), 64'(~(^exp_com(1))));
    chk("par_ceapar", 64'(ah_ceapar), 64'(~(^exp_cea(1))));
`else
    chk("par_ctagpar_tied", 64'(ah_ctagpar), 64'd1);
    chk("par_compar_tied", 64'(ah_compar), 64'd1);
    chk("par_ceapar_tied", 64'(ah_ceapar), 64'd1);
`endif
    rsp(8'd0, 9'd0, 8'h77); ha_rtagpar = 1'b0; tick(); rsp_off();
`ifdef PSL_CMD_PARITY_EN
    chk("par_bad_err", 64'(err), 64'd1);
    chk("par_bad_no_rsp", 64'(rsp_valid), 64'd0);
    chk("par_bad_outstanding", 64'(outstanding), 64'd1);
`else
    chk("par_ignored_err", 64'(err), 64'd0);
    chk("par_ignored_rsp", 64'(rsp_valid), 64'b0010);
    chk("par_ignored_outstanding", 64'(outstanding), 64'd0);
`endif

    // reset in the middle of operation
    req_valid = 4'b0001; tick(); req_valid = 4'b0000;
    chk("mr_cvalid_before", 64'(ah_cvalid), 64'd1);
    #2 ha_reset_n = 1'b0;
    #1;
    chk("mr_cvalid", 64'(ah_cvalid), 64'd0);
    chk("mr_credits", 64'(credits), 64'd0);
    chk("mr_outstanding", 64'(outstanding), 64'd0);
    tick();
    ha_reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
